// File: rtl/swan128_pkg.sv
// ---------------------------------------------------------------------------
// swan128_pkg
// Shared definitions for the SWAN-128 core scheduler: default block/key
// widths, default WAIT timeout, FSM state encoding and a small helper used
// to size the WAIT counter.
// ---------------------------------------------------------------------------
package swan128_pkg;

    localparam int SWAN_BLOCK_SIZE = 128;
    localparam int SWAN_KEY_SIZE   = 256;
    localparam int SWAN_TIMEOUT    = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } sched_state_t;

    // Number of bits needed to hold values 0..max_val (at least 1).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/swan_rr_arb2.sv
// ---------------------------------------------------------------------------
// swan_rr_arb2
// Two-way round-robin arbiter (combinational). The requester named by ptr
// wins when both request; a lone requester always wins.
//   req   in  [1:0]  request vector
//   ptr   in  1      preferred requester index
//   grant out [1:0]  one-hot grant (all zero when no request)
// ---------------------------------------------------------------------------
module swan_rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            // Requester gi wins if it holds the pointer or the other side is silent.
            assign grant[gi] = req[gi] && ((ptr == 1'(gi)) || !req[1-gi]);
        end
    endgenerate

endmodule

// File: rtl/swan128_core_sched.sv
// ---------------------------------------------------------------------------
// swan128_core_sched
// Schedules jobs from two requesters onto one shared encrypt core and one
// shared decrypt core, one job in flight at a time.
//   clk, rst                 clock / asynchronous active-high reset
//   req*/mode*/key*/inp*     requester job request and operands
//   gnt0/gnt1                one-cycle accept pulse (operands sampled then)
//   rsp_valid/ready/id/err/data  result channel (valid/ready handshake)
//   enc_start/dec_start      one-cycle start to the selected core
//   core_inp/core_key        registered operands to both cores
//   enc_ready/dec_ready, enc_out/dec_out   core status and results
//   core_rst_n               active-low synchronous reset to both cores
// ---------------------------------------------------------------------------
module swan128_core_sched
    import swan128_pkg::*;
#(
    parameter int BLOCK_SIZE = SWAN_BLOCK_SIZE,
    parameter int KEY_SIZE   = SWAN_KEY_SIZE,
    parameter int TIMEOUT    = SWAN_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  mode0,
    input  logic                  mode1,
    input  logic [KEY_SIZE-1:0]   key0,
    input  logic [KEY_SIZE-1:0]   key1,
    input  logic [BLOCK_SIZE-1:0] inp0,
    input  logic [BLOCK_SIZE-1:0] inp1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic                  rsp_err,
    output logic [BLOCK_SIZE-1:0] rsp_data,
    output logic                  enc_start,
    output logic                  dec_start,
    output logic [BLOCK_SIZE-1:0] core_inp,
    output logic [KEY_SIZE-1:0]   core_key,
    input  logic                  enc_ready,
    input  logic                  dec_ready,
    input  logic [BLOCK_SIZE-1:0] enc_out,
    input  logic [BLOCK_SIZE-1:0] dec_out,
    output logic                  core_rst_n
);

    localparam int               CNT_W       = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    sched_state_t          state_reg;
    logic                  ptr_reg;
    logic                  mode_reg;
    logic                  id_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  enc_start_reg;
    logic                  dec_start_reg;
    logic                  rsp_valid_reg;
    logic                  rsp_err_reg;
    logic [BLOCK_SIZE-1:0] rsp_data_reg;
    logic [BLOCK_SIZE-1:0] core_inp_reg;
    logic [KEY_SIZE-1:0]   core_key_reg;
    logic                  core_rst_n_reg;

    logic [1:0]            arb_req;
    logic [1:0]            arb_grant;
    logic                  idle_grant;
    logic                  win_mode;
    logic                  sel_ready;
    logic [BLOCK_SIZE-1:0] sel_out;

    assign arb_req = {req1, req0};

    swan_rr_arb2 u_arb (
        .req   (arb_req),
        .ptr   (ptr_reg),
        .grant (arb_grant)
    );

    // Grants are only issued from IDLE and are suppressed while reset is high.
    assign idle_grant = (state_reg == ST_IDLE) && !rst;
    assign gnt0       = idle_grant && arb_grant[0];
    assign gnt1       = idle_grant && arb_grant[1];
    assign win_mode   = arb_grant[1] ? mode1 : mode0;

    // Only the core selected by the job's mode is ever observed.
    assign sel_ready = mode_reg ? dec_ready : enc_ready;
    assign sel_out   = mode_reg ? dec_out   : enc_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            ptr_reg        <= 1'b0;
            mode_reg       <= 1'b0;
            id_reg         <= 1'b0;
            cnt_reg        <= '0;
            enc_start_reg  <= 1'b0;
            dec_start_reg  <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_err_reg    <= 1'b0;
            rsp_data_reg   <= '0;
            core_inp_reg   <= '0;
            core_key_reg   <= '0;
            core_rst_n_reg <= 1'b0;
        end else begin
            // Core reset and start strobes are single-cycle unless re-armed below.
            core_rst_n_reg <= 1'b1;
            enc_start_reg  <= 1'b0;
            dec_start_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (|arb_grant) begin
                        mode_reg      <= win_mode;
                        id_reg        <= arb_grant[1];
                        core_inp_reg  <= arb_grant[1] ? inp1 : inp0;
                        core_key_reg  <= arb_grant[1] ? key1 : key0;
                        // Start is raised for the LOAD cycle that follows.
                        enc_start_reg <= !win_mode;
                        dec_start_reg <= win_mode;
                        state_reg     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt_reg   <= '0;
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    // cnt_reg == 0 is the blanking cycle: the core may still be
                    // showing ready from its previous job.
                    if ((cnt_reg != '0) && sel_ready) begin
                        rsp_data_reg  <= sel_out;
                        rsp_err_reg   <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= ST_RESP;
                    end else if (cnt_reg == TIMEOUT_CNT) begin
                        rsp_data_reg   <= '0;
                        rsp_err_reg    <= 1'b1;
                        rsp_valid_reg  <= 1'b1;
                        core_rst_n_reg <= 1'b0;
                        state_reg      <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        ptr_reg       <= !id_reg;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign enc_start  = enc_start_reg;
    assign dec_start  = dec_start_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_id     = id_reg;
    assign rsp_err    = rsp_err_reg;
    assign rsp_data   = rsp_data_reg;
    assign core_inp   = core_inp_reg;
    assign core_key   = core_key_reg;
    assign core_rst_n = core_rst_n_reg;

endmodule
